// File: rtl/intr_ctrl.sv
// intr_ctrl: 8-level nested priority interrupt controller.
// Define INTC_MASK_EN to build the per-line enable mask register.
module intr_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irq,
  input  logic [7:0] s_calli,
  input  logic [7:0] s_reti,
  output logic [7:0] max_bit_s,
  output logic [7:0] max_bit_a
`ifdef INTC_MASK_EN
  ,
  input  logic       imask_we,
  input  logic [7:0] imask_d
`endif
);

  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [7:0] sync2_d;
  logic [7:0] pending;
  logic [7:0] in_service;
  logic [7:0] enable;
  logic [7:0] rise;

  function automatic logic [7:0] msb1(
    input logic [7:0] v
  );
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

`ifdef INTC_MASK_EN
  logic [7:0] mask;

  // mask register, all lines enabled out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask <= 8'hFF;
    end else if (imask_we) begin
      mask <= imask_d;
    end
  end

  assign enable = mask;
`else
  assign enable = 8'hFF;
`endif

  // a level produces one event, on its synchronized rising edge
  assign rise = sync2 & ~sync2_d;

  // synchronizer chain plus edge-detect delay flop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      sync2_d <= '0;
    end else begin
      sync1   <= irq;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  // pending: new event beats a coincident acknowledge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~s_calli) | rise;
    end
  end

  // in_service: return beats a coincident entry on the same bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_service <= '0;
    end else begin
      in_service <= (in_service | s_calli) & ~s_reti;
    end
  end

  // priority decodes straight off registered state
  always_comb begin
    max_bit_s = msb1((pending & enable) | in_service);
    max_bit_a = msb1(in_service);
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: randomized and directed checks of intr_ctrl
// against an irq-history reference model.
module tb_intr_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] irq;
  logic [7:0] s_calli;
  logic [7:0] s_reti;
  logic [7:0] max_bit_s;
  logic [7:0] max_bit_a;
`ifdef INTC_MASK_EN
  logic       imask_we;
  logic [7:0] imask_d;
`endif

  int total;
  int bad;

  logic [7:0] m_pend;
  logic [7:0] m_ins;
  logic [7:0] m_mask;
  logic [7:0] hist[$];

  intr_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .irq      (irq),
    .s_calli  (s_calli),
    .s_reti   (s_reti),
    .max_bit_s(max_bit_s),
    .max_bit_a(max_bit_a)
`ifdef INTC_MASK_EN
    ,
    .imask_we (imask_we),
    .imask_d  (imask_d)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] top(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) return 8'(1 << i);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_s();
    return top((m_pend & m_mask) | m_ins);
  endfunction

  function automatic logic [7:0] exp_a();
    return top(m_ins);
  endfunction

  task automatic model_clear();
    m_pend = '0;
    m_ins  = '0;
    m_mask = 8'hFF;
    hist.delete();
  endtask

  // one clock: a line counts as a new event when it was seen high two
  // edges ago and low three edges ago (anything before reset is low)
  task automatic step(input logic [7:0] i, input logic [7:0] c,
                      input logic [7:0] r);
    logic [7:0] a2;
    logic [7:0] a3;
    int n;
    irq     = i;
    s_calli = c;
    s_reti  = r;
    @(posedge clk);
    n  = hist.size();
    a2 = (n >= 2) ? hist[n-2] : 8'h00;
    a3 = (n >= 3) ? hist[n-3] : 8'h00;
    m_pend = (m_pend & ~c) | (a2 & ~a3);
    m_ins  = (m_ins | c) & ~r;
`ifdef INTC_MASK_EN
    if (imask_we) m_mask = imask_d;
`endif
    hist.push_back(i);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    irq     = '0;
    s_calli = '0;
    s_reti  = '0;
`ifdef INTC_MASK_EN
    imask_we = 1'b0;
    imask_d  = '0;
`endif
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (max_bit_s !== 8'h00) begin
      bad++;
      $display("FAIL reset_s got=%h want=00", max_bit_s);
    end
    total++;
    if (max_bit_a !== 8'h00) begin
      bad++;
      $display("FAIL reset_a got=%h want=00", max_bit_a);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_idle();
    for (int k = 0; k < 20; k++) begin
      step(8'h00, 8'h00, 8'h00);
      total++;
      if (max_bit_s !== 8'h00 || max_bit_a !== 8'h00) begin
        bad++;
        $display("FAIL idle[%0d] got s=%h a=%h want 00/00",
                 k, max_bit_s, max_bit_a);
      end
    end
  endtask

  task automatic test_latency();
    logic [7:0] want[3];
    want[0] = 8'h00;
    want[1] = 8'h00;
    want[2] = 8'h04;
    for (int k = 0; k < 3; k++) begin
      step(8'h04, 8'h00, 8'h00);
      total++;
      if (max_bit_s !== want[k]) begin
        bad++;
        $display("FAIL latency[%0d] got s=%h want=%h",
                 k, max_bit_s, want[k]);
      end
    end
    step(8'h04, 8'h04, 8'h00);
    total++;
    if (max_bit_s !== 8'h04 || max_bit_a !== 8'h04) begin
      bad++;
      $display("FAIL latency_call got s=%h a=%h want 04/04",
               max_bit_s, max_bit_a);
    end
    step(8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_nesting();
    step(8'h40, 8'h00, 8'h00);
    step(8'h00, 8'h00, 8'h00);
    step(8'h00, 8'h00, 8'h00);
    total++;
    if (max_bit_s !== 8'h40 || max_bit_a !== 8'h04) begin
      bad++;
      $display("FAIL nest_pend got s=%h a=%h want 40/04",
               max_bit_s, max_bit_a);
    end
    step(8'h00, 8'h40, 8'h00);
    total++;
    if (max_bit_a !== 8'h40) begin
      bad++;
      $display("FAIL nest_call got a=%h want=40", max_bit_a);
    end
    step(8'h00, 8'h00, 8'h40);
    total++;
    if (max_bit_a !== 8'h04 || max_bit_s !== 8'h04) begin
      bad++;
      $display("FAIL nest_ret6 got s=%h a=%h want 04/04",
               max_bit_s, max_bit_a);
    end
    step(8'h00, 8'h00, 8'h04);
    total++;
    if (max_bit_s !== 8'h00 || max_bit_a !== 8'h00) begin
      bad++;
      $display("FAIL nest_ret2 got s=%h a=%h want 00/00",
               max_bit_s, max_bit_a);
    end
  endtask

  task automatic test_low_hold();
    step(8'h00, 8'h20, 8'h00);
    step(8'h02, 8'h00, 8'h00);
    step(8'h00, 8'h00, 8'h00);
    step(8'h00, 8'h00, 8'h00);
    total++;
    if (max_bit_s !== 8'h20 || max_bit_a !== 8'h20) begin
      bad++;
      $display("FAIL hold got s=%h a=%h want 20/20",
               max_bit_s, max_bit_a);
    end
    step(8'h00, 8'h00, 8'h20);
    total++;
    if (max_bit_s !== 8'h02 || max_bit_a !== 8'h00) begin
      bad++;
      $display("FAIL hold_release got s=%h a=%h want 02/00",
               max_bit_s, max_bit_a);
    end
    step(8'h00, 8'h02, 8'h00);
    step(8'h00, 8'h00, 8'h02);
  endtask

  task automatic test_set_wins();
    step(8'h08, 8'h00, 8'h00);
    step(8'h00, 8'h00, 8'h00);
    step(8'h00, 8'h08, 8'h00);
    total++;
    if (max_bit_s !== 8'h08 || max_bit_a !== 8'h08) begin
      bad++;
      $display("FAIL setwin got s=%h a=%h want 08/08",
               max_bit_s, max_bit_a);
    end
    step(8'h00, 8'h00, 8'h08);
    total++;
    if (max_bit_s !== 8'h08 || max_bit_a !== 8'h00) begin
      bad++;
      $display("FAIL setwin_ret got s=%h a=%h want 08/00",
               max_bit_s, max_bit_a);
    end
    step(8'h00, 8'h08, 8'h08);
    total++;
    if (max_bit_s !== 8'h00 || max_bit_a !== 8'h00) begin
      bad++;
      $display("FAIL call_ret_same got s=%h a=%h want 00/00",
               max_bit_s, max_bit_a);
    end
  endtask

`ifdef INTC_MASK_EN
  task automatic test_mask();
    imask_we = 1'b1;
    imask_d  = 8'h7F;
    step(8'h80, 8'h00, 8'h00);
    imask_we = 1'b0;
    step(8'h00, 8'h00, 8'h00);
    step(8'h00, 8'h00, 8'h00);
    step(8'h00, 8'h00, 8'h00);
    total++;
    if (max_bit_s !== 8'h00) begin
      bad++;
      $display("FAIL mask_hide got s=%h want=00", max_bit_s);
    end
    imask_we = 1'b1;
    imask_d  = 8'hFF;
    step(8'h00, 8'h00, 8'h00);
    imask_we = 1'b0;
    total++;
    if (max_bit_s !== 8'h80) begin
      bad++;
      $display("FAIL mask_show got s=%h want=80", max_bit_s);
    end
    imask_we = 1'b1;
    imask_d  = 8'h00;
    step(8'h00, 8'h00, 8'h00);
    imask_we = 1'b0;
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    total++;
    if (max_bit_s !== 8'h00 || max_bit_a !== 8'h00) begin
      bad++;
      $display("FAIL mask_rst got s=%h a=%h want 00/00",
               max_bit_s, max_bit_a);
    end
    @(negedge clk);
    reset = 1'b1;
    step(8'h00, 8'h01, 8'h00);
    step(8'h00, 8'h00, 8'h00);
    total++;
    if (max_bit_s !== 8'h01) begin
      bad++;
      $display("FAIL mask_rst_val got s=%h want=01", max_bit_s);
    end
    step(8'h00, 8'h00, 8'h01);
  endtask
`endif

  task automatic test_random();
    logic [7:0] i;
    logic [7:0] c;
    logic [7:0] r;
    for (int k = 0; k < 400; k++) begin
      i = 8'($urandom & $urandom & $urandom);
      c = ($urandom_range(0, 2) == 0) ?
          8'(1 << $urandom_range(0, 7)) : 8'h00;
      r = ($urandom_range(0, 2) == 0) ?
          8'($urandom & $urandom) : 8'h00;
      if ($urandom_range(0, 9) == 0) c = 8'($urandom);
`ifdef INTC_MASK_EN
      imask_we = ($urandom_range(0, 15) == 0);
      imask_d  = 8'($urandom);
`endif
      step(i, c, r);
      total++;
      if (max_bit_s !== exp_s() || max_bit_a !== exp_a()) begin
        bad++;
        $display("FAIL rand[%0d] got s=%h a=%h want %h/%h",
                 k, max_bit_s, max_bit_a, exp_s(), exp_a());
      end
    end
`ifdef INTC_MASK_EN
    imask_we = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    logic [7:0] want[3];
    want[0] = 8'h00;
    want[1] = 8'h00;
    want[2] = 8'h10;
    step(8'h00, 8'h22, 8'h00);
    step(8'h80, 8'h00, 8'h00);
    step(8'h80, 8'h00, 8'h00);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    total++;
    if (max_bit_s !== 8'h00 || max_bit_a !== 8'h00) begin
      bad++;
      $display("FAIL rst_mid got s=%h a=%h want 00/00",
               max_bit_s, max_bit_a);
    end
    irq     = 8'h10;
    s_calli = '0;
    s_reti  = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (max_bit_s !== 8'h00 || max_bit_a !== 8'h00) begin
      bad++;
      $display("FAIL rst_hold got s=%h a=%h want 00/00",
               max_bit_s, max_bit_a);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(8'h10, 8'h00, 8'h00);
      total++;
      if (max_bit_s !== want[k]) begin
        bad++;
        $display("FAIL rst_edge[%0d] got s=%h want=%h",
                 k, max_bit_s, want[k]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_idle();
    test_latency();
    test_nesting();
    test_low_hold();
    test_set_wins();
`ifdef INTC_MASK_EN
    test_mask();
`endif
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
